// File: rtl/dc_buffer_reader.sv
// dc_buffer_reader: read side of a toggle-token dual-clock slot buffer.
// Synchronizes writer tokens and streams slots out through a valid/ready register.
module dc_buffer_reader #(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [BUFFER_DEPTH-1:0] write_token,
    output logic [BUFFER_DEPTH-1:0] read_token,
    output logic [BUFFER_DEPTH-1:0] read_pointer,
    input  logic [DATA_WIDTH-1:0]   read_data,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    data_valid,
    input  logic                    data_ready
);

    logic [BUFFER_DEPTH-1:0] sync1;
    logic [BUFFER_DEPTH-1:0] sync2;
    logic [BUFFER_DEPTH-1:0] full;
    logic                    avail;
    logic                    free;
    logic                    pop;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= write_token;
            sync2 <= sync1;
        end
    end

    // A slot holds data while its two tokens disagree.
    assign full  = sync2 ^ read_token;
    assign avail = |(full & read_pointer);
    assign free  = !data_valid || data_ready;
    assign pop   = avail && free;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            read_pointer <= {{(BUFFER_DEPTH-1){1'b0}}, 1'b1};
            read_token   <= '0;
            data_out     <= '0;
            data_valid   <= 1'b0;
        end else if (pop) begin
            data_out     <= read_data;
            data_valid   <= 1'b1;
            read_token   <= read_token ^ read_pointer;
            read_pointer <= {read_pointer[BUFFER_DEPTH-2:0],
                             read_pointer[BUFFER_DEPTH-1]};
        end else if (free) begin
            data_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dc_buffer_reader.sv
// tb_dc_buffer_reader: directed and randomized checks of dc_buffer_reader
// against an in-order word queue and pop-count model.
module tb_dc_buffer_reader;

    localparam int DW = 32;
    localparam int BD = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic [BD-1:0] write_token = '0;
    logic [BD-1:0] read_token;
    logic [BD-1:0] read_pointer;
    logic [DW-1:0] read_data;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          data_ready = 1'b0;

    logic [DW-1:0] mem [BD];
    logic [DW-1:0] q [$];
    int            total = 0;
    int            bad = 0;
    int            consumed = 0;
    int            wp = 0;
    bit            sb_on = 1'b0;

    always #5 clk = ~clk;

    dc_buffer_reader #(
        .DATA_WIDTH  (DW),
        .BUFFER_DEPTH(BD)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .write_token (write_token),
        .read_token  (read_token),
        .read_pointer(read_pointer),
        .read_data   (read_data),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready)
    );

    always_comb begin
        read_data = '0;
        for (int k = 0; k < BD; k++)
            if (read_pointer[k]) read_data = mem[k];
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // After n pops the pointer sits at slot n mod depth.
    function automatic logic [BD-1:0] exp_rp(input int n);
        logic [BD-1:0] r;
        r = '0;
        r[n % BD] = 1'b1;
        return r;
    endfunction

    // Slot k has been read (n/depth) times plus once more if k < n mod depth.
    function automatic logic [BD-1:0] exp_rt(input int n);
        logic [BD-1:0] r;
        for (int k = 0; k < BD; k++)
            r[k] = 1'((n / BD + ((k < n % BD) ? 1 : 0)) % 2);
        return r;
    endfunction

    task automatic tick();
        bit hs;
        int n;
        hs = data_valid && data_ready;
        @(posedge clk);
        #1;
        if (sb_on) begin
            if (hs) begin
                if (q.size() > 0) void'(q.pop_front());
                consumed++;
            end
            n = consumed + (data_valid ? 1 : 0);
            check("rand_rp", read_pointer, exp_rp(n));
            check("rand_rt", read_token, exp_rt(n));
            if (data_valid) begin
                check("rand_qlen", q.size() > 0, 1);
                if (q.size() > 0) check("rand_dout", data_out, q[0]);
            end
        end
    endtask

    task automatic put_word(input logic [DW-1:0] w);
        mem[wp] = w;
        write_token[wp] = ~write_token[wp];
        q.push_back(w);
        wp = (wp + 1) % BD;
    endtask

    task automatic do_reset();
        sb_on = 1'b0;
        #1;
        rstn = 1'b0;
        write_token = '0;
        data_ready = 1'b0;
        wp = 0;
        consumed = 0;
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        check("rst_dv", data_valid, 0);
        check("rst_dout", data_out, 0);
        check("rst_rp", read_pointer, 8'h01);
        check("rst_rt", read_token, 8'h00);
    endtask

    initial begin
        for (int k = 0; k < BD; k++) mem[k] = '0;

        // Idle after reset: ready has no effect with nothing written.
        do_reset();
        data_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_dv", data_valid, 0);
            check("idle_rp", read_pointer, 8'h01);
            check("idle_rt", read_token, 8'h00);
        end

        // Single word latency.
        do_reset();
        data_ready = 1'b1;
        mem[0] = 32'hA5A5_0001;
        write_token = 8'h01;
        tick();
        check("lat_dv1", data_valid, 0);
        tick();
        check("lat_dv2", data_valid, 0);
        tick();
        check("lat_dv3", data_valid, 1);
        check("lat_dout", data_out, 32'hA5A5_0001);
        check("lat_rp", read_pointer, 8'h02);
        check("lat_rt", read_token, 8'h01);
        tick();
        check("lat_dv4", data_valid, 0);

        // Full lap at one word per cycle, then second lap on slot 0.
        do_reset();
        data_ready = 1'b1;
        for (int k = 0; k < BD; k++) mem[k] = 32'hC0DE_0000 + k;
        write_token = 8'hFF;
        tick();
        tick();
        for (int k = 0; k < BD; k++) begin
            tick();
            check("lap_dv", data_valid, 1);
            check("lap_dout", data_out, 32'hC0DE_0000 + k);
        end
        check("lap_rp", read_pointer, 8'h01);
        check("lap_rt", read_token, 8'hFF);
        tick();
        check("lap_dv_end", data_valid, 0);
        mem[0] = 32'h5EC0_0000;
        write_token[0] = 1'b0;
        repeat (3) tick();
        check("lap2_dv", data_valid, 1);
        check("lap2_dout", data_out, 32'h5EC0_0000);
        check("lap2_rt", read_token, 8'hFE);
        check("lap2_rp", read_pointer, 8'h02);

        // Backpressure holds the word and the pointer.
        do_reset();
        for (int k = 0; k < 3; k++) mem[k] = 32'hB000_0010 + k;
        write_token = 8'h07;
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_dv", data_valid, 1);
            check("bp_dout", data_out, 32'hB000_0010);
            check("bp_rp", read_pointer, 8'h02);
        end
        data_ready = 1'b1;
        tick();
        check("bp_dout1", data_out, 32'hB000_0011);
        check("bp_rp1", read_pointer, 8'h04);
        tick();
        check("bp_dout2", data_out, 32'hB000_0012);
        check("bp_dv2", data_valid, 1);
        tick();
        check("bp_dv3", data_valid, 0);
        check("bp_rt", read_token, 8'h07);

        // Asynchronous reset mid-stream.
        do_reset();
        for (int k = 0; k < 4; k++) mem[k] = 32'hDEAD_0000 + k;
        write_token = 8'h0F;
        repeat (3) tick();
        check("ar_pre_dv", data_valid, 1);
        #2;
        rstn = 1'b0;
        write_token = '0;
        #1;
        check("ar_dv", data_valid, 0);
        check("ar_dout", data_out, 0);
        check("ar_rt", read_token, 8'h00);
        check("ar_rp", read_pointer, 8'h01);
        tick();
        rstn = 1'b1;
        data_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("ar_post_dv", data_valid, 0);
        end

        // Randomized traffic against the queue model.
        do_reset();
        sb_on = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            data_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1 && write_token[wp] == read_token[wp])
                put_word($urandom);
            tick();
        end
        data_ready = 1'b1;
        repeat (30) tick();
        check("drain_q", q.size(), 0);
        check("drain_dv", data_valid, 0);
        sb_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
